// File: rtl/window_write_sequencer.sv
// Window-fill write sequencer: stamps accepted beats with (row, block) indices and
// drives the alignment stage, then waits out the alignment pipeline before pulsing done.
module window_write_sequencer #(
  parameter int unsigned WORDS       = 16,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned PIPE_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [INDEX_WIDTH-1:0]       cfg_rows,
  input  logic [INDEX_WIDTH-1:0]       cfg_blocks,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORDS*WORD_SIZE-1:0]   in_data,
  output logic                         out_we,
  output logic [INDEX_WIDTH-1:0]       out_waddrY,
  output logic [INDEX_WIDTH-1:0]       out_waddrBlock,
  output logic [WORDS*WORD_SIZE-1:0]   out_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         err_cfg
);

  localparam int unsigned DrainW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [INDEX_WIDTH-1:0] IdxOne = INDEX_WIDTH'(1);
  localparam logic [DrainW-1:0] DrainOne = DrainW'(1);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(PIPE_LAT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] rows_q;
  logic [INDEX_WIDTH-1:0] blocks_q;
  logic [INDEX_WIDTH-1:0] row_q;
  logic [INDEX_WIDTH-1:0] blk_q;
  logic [DrainW-1:0]      drain_q;

  logic last_blk;
  logic last_row;
  logic accept;

  assign last_blk = (blk_q == blocks_q - IdxOne);
  assign last_row = (row_q == rows_q - IdxOne);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rows_q         <= '0;
      blocks_q       <= '0;
      row_q          <= '0;
      blk_q          <= '0;
      drain_q        <= '0;
      in_ready       <= 1'b0;
      out_we         <= 1'b0;
      out_waddrY     <= '0;
      out_waddrBlock <= '0;
      out_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      out_we  <= 1'b0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (abort) begin
        // Abort wins over start, beats and completion; addresses/data simply hold.
        state_q  <= StIdle;
        row_q    <= '0;
        blk_q    <= '0;
        drain_q  <= '0;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (cfg_rows == '0 || cfg_blocks == '0) begin
                err_cfg <= 1'b1;
              end else begin
                rows_q   <= cfg_rows;
                blocks_q <= cfg_blocks;
                row_q    <= '0;
                blk_q    <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                state_q  <= StRun;
              end
            end
          end
          StRun: begin
            if (accept) begin
              out_we         <= 1'b1;
              out_wdata      <= in_data;
              out_waddrY     <= row_q;
              out_waddrBlock <= blk_q;
              if (last_blk) begin
                blk_q <= '0;
                if (last_row) begin
                  in_ready <= 1'b0;
                  drain_q  <= DrainInit;
                  state_q  <= StDrain;
                end else begin
                  row_q <= row_q + IdxOne;
                end
              end else begin
                blk_q <= blk_q + IdxOne;
              end
            end
          end
          StDrain: begin
            if (drain_q <= DrainOne) begin
              busy    <= 1'b0;
              state_q <= StDone;
            end else begin
              drain_q <= drain_q - DrainOne;
            end
          end
          StDone: begin
            done    <= 1'b1;
            row_q   <= '0;
            blk_q   <= '0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_write_sequencer.sv
// Directed bench for window_write_sequencer: a beat-count based reference model checked
// every cycle, plus literal expectations for write order, latency and pulse counts.
module tb_window_write_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned WS = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned PL = 2;
  localparam int unsigned DW = W * WS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] cfg_rows = '0;
  logic [IW-1:0] cfg_blocks = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_we;
  logic [IW-1:0] out_waddrY;
  logic [IW-1:0] out_waddrBlock;
  logic [DW-1:0] out_wdata;
  logic          busy;
  logic          done;
  logic          err_cfg;

  window_write_sequencer #(
    .WORDS      (W),
    .WORD_SIZE  (WS),
    .INDEX_WIDTH(IW),
    .PIPE_LAT   (PL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_rows      (cfg_rows),
    .cfg_blocks    (cfg_blocks),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_we        (out_we),
    .out_waddrY    (out_waddrY),
    .out_waddrBlock(out_waddrBlock),
    .out_wdata     (out_wdata),
    .busy          (busy),
    .done          (done),
    .err_cfg       (err_cfg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] v;
    v = 32'(k);
    return {v * 32'h9E37_79B1, 32'hA5C3_0000 + v, ~v, v << 3};
  endfunction

  // Reference model: phases plus a linear beat index k; (row, block) = (k / blocks, k % blocks).
  int            m_mode = 0;  // 0 idle, 1 streaming, 2 waiting for pipeline
  int            m_k = 0;
  int            m_total = 0;
  int            m_blocks = 1;
  int            m_since = 0;
  logic          e_ready = 1'b0;
  logic          e_we = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;
  logic          e_err = 1'b0;
  logic [IW-1:0] e_y = '0;
  logic [IW-1:0] e_b = '0;
  logic [DW-1:0] e_data = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_k = 0;
      e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_y = '0; e_b = '0; e_data = '0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (abort) begin
        m_mode = 0; e_ready = 0; e_busy = 0;
      end else if (m_mode == 0) begin
        if (start) begin
          if (cfg_rows == 0 || cfg_blocks == 0) e_err = 1;
          else begin
            m_blocks = int'(cfg_blocks);
            m_total  = int'(cfg_rows) * int'(cfg_blocks);
            m_k = 0; m_mode = 1; e_ready = 1; e_busy = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (in_valid) begin
          e_we = 1;
          e_y = IW'(m_k / m_blocks);
          e_b = IW'(m_k % m_blocks);
          e_data = in_data;
          m_k++;
          if (m_k == m_total) begin
            m_mode = 2; m_since = 0; e_ready = 0;
          end
        end
      end else begin
        // m_since counts cycles after the last write cycle.
        m_since++;
        if (m_since == PL) e_busy = 0;
        if (m_since == PL + 1) begin
          e_done = 1; m_mode = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_in_ready", in_ready, e_ready);
    chk("cmp_out_we", out_we, e_we);
    chk("cmp_busy", busy, e_busy);
    chk("cmp_done", done, e_done);
    chk("cmp_err_cfg", err_cfg, e_err);
    chk("cmp_waddrY", out_waddrY, e_y);
    chk("cmp_waddrBlock", out_waddrBlock, e_b);
    chk("cmp_wdata", out_wdata, e_data);
  end

  // Write/pulse log for the literal expectations.
  logic [IW-1:0] wy[$];
  logic [IW-1:0] wb[$];
  logic [DW-1:0] wd[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (out_we) begin
      wy.push_back(out_waddrY);
      wb.push_back(out_waddrBlock);
      wd.push_back(out_wdata);
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_cfg) err_cnt++;
  end

  task automatic clear_log();
    wy.delete(); wb.delete(); wd.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", (done_cnt > 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic begin_fill(input int rows, input int blocks);
    start = 1; cfg_rows = IW'(rows); cfg_blocks = IW'(blocks);
    @(negedge clk);
    start = 0;
  endtask

  task automatic check_order_2x3(input string tag);
    logic [IW-1:0] ey[6];
    logic [IW-1:0] eb[6];
    ey = '{0, 0, 0, 1, 1, 1};
    eb = '{0, 1, 2, 0, 1, 2};
    chk({tag, "_write_count"}, wy.size(), 6);
    for (int i = 0; i < 6 && i < wy.size(); i++) begin
      chk({tag, "_Y"}, wy[i], ey[i]);
      chk({tag, "_Block"}, wb[i], eb[i]);
    end
  endtask

  initial begin
    // Reset held with a valid beat presented.
    in_valid = 1; in_data = '1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_waddrY", out_waddrY, 0);
    chk("rst_waddrBlock", out_waddrBlock, 0);
    chk("rst_wdata", out_wdata, 0);
    rst_n = 1; in_valid = 0;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // Full back-to-back stream, 2 rows x 3 blocks.
    clear_log();
    begin_fill(2, 3);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = pat(k);
      @(negedge clk);
    end
    in_valid = 0;
    wait_done(50);
    check_order_2x3("full");
    for (int i = 0; i < 6 && i < wd.size(); i++) chk("full_wdata", wd[i], pat(i));
    chk("full_done_count", done_cnt, 1);
    chk("full_done_latency", done_cyc - last_we_cyc, PL + 1);

    // Bubbles: valid 1,0,0,... and a stray bad-config start mid-fill that must be ignored.
    clear_log();
    begin_fill(2, 3);
    for (int i = 0; i < 18; i++) begin
      in_valid = (i % 3 == 0);
      in_data = pat(100 + i);
      start = (i == 4);
      if (i == 4) cfg_blocks = 0;
      @(negedge clk);
    end
    start = 0; in_valid = 0;
    wait_done(50);
    check_order_2x3("bubble");
    for (int j = 0; j < 6 && j < wd.size(); j++) chk("bubble_wdata", wd[j], pat(100 + 3 * j));
    chk("bubble_done_count", done_cnt, 1);
    chk("bubble_no_err", err_cnt, 0);

    // Bad config.
    clear_log();
    begin_fill(2, 0);
    repeat (4) @(negedge clk);
    chk("badcfg_err_count", err_cnt, 1);
    chk("badcfg_writes", wy.size(), 0);
    chk("badcfg_busy", busy, 0);

    // Simultaneous start and abort in idle.
    abort = 1;
    begin_fill(2, 3);
    abort = 0;
    repeat (2) @(negedge clk);
    chk("startabort_busy", busy, 0);
    chk("startabort_ready", in_ready, 0);

    // Abort on the 4th accepted beat.
    clear_log();
    begin_fill(2, 3);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = pat(200 + k); abort = (k == 3);
      @(negedge clk);
    end
    abort = 0; in_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    repeat (6) @(negedge clk);
    chk("abort_writes", wy.size(), 3);
    chk("abort_no_done", done_cnt, 0);

    // Restart after abort begins at (0,0).
    clear_log();
    begin_fill(1, 2);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_data = pat(300 + k);
      @(negedge clk);
    end
    in_valid = 0;
    wait_done(50);
    chk("restart_writes", wy.size(), 2);
    if (wy.size() == 2) begin
      chk("restart_Y0", wy[0], 0);
      chk("restart_B0", wb[0], 0);
      chk("restart_B1", wb[1], 1);
    end
    chk("restart_done_count", done_cnt, 1);

    // Async reset mid-fill, between clock edges.
    clear_log();
    begin_fill(2, 3);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_data = pat(400 + k);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_we", out_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_waddrBlock", out_waddrBlock, 0);
    chk("arst_wdata", out_wdata, 0);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);
    chk("arst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_write_sequencer.md
Name: window_write_sequencer

Overview:
- Controller that sequences the window-alignment write path for one window fill.
- Accepts a valid/ready stream of WORDS-wide data beats from the line fetcher.
- Stamps each accepted beat with a row index (waddrY) and block index (waddrBlock) plus a write-enable, then drives the alignment stage fields.
- Walks a configurable rows x blocks window, waits for the fixed alignment-pipeline latency to drain, then signals completion.

Parameters:
- WORDS, 16, data words per beat.
- WORD_SIZE, 8, bits per word.
- INDEX_WIDTH, 8, width of row and block indices.
- PIPE_LAT, 2, cycles from out_we to the write landing in window memory; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a fill. Honoured only in IDLE.
- abort  in  1  synchronous; terminates any fill.
- cfg_rows  in  INDEX_WIDTH  number of rows, sampled at start.
- cfg_blocks  in  INDEX_WIDTH  blocks per row, sampled at start.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  sequencer can accept a beat.
- in_data  in  WORDS*WORD_SIZE  upstream beat; word 0 in the LSBs.
- out_we  out  1  write-enable to the alignment stage.
- out_waddrY  out  INDEX_WIDTH  row index.
- out_waddrBlock  out  INDEX_WIDTH  block index.
- out_wdata  out  WORDS*WORD_SIZE  beat data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse.
- err_cfg  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: in_ready, out_we, out_waddrY, out_waddrBlock, out_wdata, busy, done, err_cfg. Row/block counters and drain counter 0.
- Common rule: abort has priority over every other event in every state.
- IDLE:
  - start with cfg_rows==0 or cfg_blocks==0: pulse err_cfg next cycle, remain IDLE.
  - start with valid config: latch both cfg values, clear counters, go to RUN. busy and in_ready rise on the next cycle.
- RUN:
  - in_ready=1 throughout.
  - A beat is accepted on a cycle with in_valid & in_ready. The next cycle then shows out_we=1, out_wdata=in_data, out_waddrY=row counter, out_waddrBlock=block counter (registered, 1-cycle latency).
  - out_we=0 on cycles following a non-accept; addresses and data hold their last value.
  - Counter order: block is the inner loop. Block increments to cfg_blocks-1, then wraps to 0 and row increments.
  - Accepting the beat at (cfg_rows-1, cfg_blocks-1): in_ready drops the same edge; go to DRAIN with drain counter = PIPE_LAT.
  - Full back-to-back streaming sustains one write per cycle.
- DRAIN:
  - in_ready=0; out_we=0 from the cycle after the last write.
  - Drain counter decrements each cycle; at 1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - Earliest done is PIPE_LAT+1 cycles after the last out_we.
- abort, in any state:
  - Next cycle: state IDLE, in_ready=0, out_we=0, busy=0. No done pulse; counters cleared.
  - A beat presented alongside abort is discarded.
- start outside IDLE is ignored (no err_cfg).
- A simultaneous start and abort in IDLE is an abort: no fill begins.
- Index arithmetic is unsigned INDEX_WIDTH with no overflow possible, since counters never exceed cfg-1.
- Reset asserted mid-fill: immediate return to reset values; partial fill is abandoned.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1 -> all outputs 0; after release, in_ready=0 until start.
- Full stream: start, cfg_rows=2, cfg_blocks=3, in_valid continuously high ->
  - six consecutive out_we cycles with (Y,Block) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - out_wdata equals the accepted beats;
  - done exactly PIPE_LAT+1=3 cycles after the last out_we.
- Bubbles: same config, in_valid toggling 1,0,0,1,... -> out_we only after accepts; addresses hold during gaps; still six writes; one done.
- Bad config: start with cfg_blocks=0 -> err_cfg pulses once; busy stays 0; no out_we.
- Abort mid-row: abort during the 4th accepted beat ->
  - that beat never produces out_we; next cycle busy=0, in_ready=0;
  - no done;
  - a subsequent valid start restarts at (0,0).
- Async reset mid-fill: drop rst_n between clock edges during RUN -> outputs clear immediately without waiting for clk; no done after release.
